// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if: controller-to-sequencer bus; NIBBLE_ADD_SEQ_SUB_EN adds the op (subtract) signal
interface nibble_add_seq_if #(parameter int NIBBLES = 4);
    logic                   start;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic                   op;
`endif
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   sum;
    logic                   cout;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    modport master(output start, a, b, cin, op, input busy, done, sum, cout);
    modport slave(input start, a, b, cin, op, output busy, done, sum, cout);
`else
    modport master(output start, a, b, cin, input busy, done, sum, cout);
    modport slave(input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide add one nibble per clock through a shared 4-bit ripple adder;
// NIBBLE_ADD_SEQ_SUB_EN enables A-B when op=1 (cout=1 means no borrow).
module fulladdR (
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    input  logic       cin,
    output logic [3:0] o,
    output logic       cout
);
    logic c;
    always_comb begin
        c = cin;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            o[i] = i0[i] ^ i1[i] ^ c;
            c = (i0[i] & i1[i]) | (c & (i0[i] ^ i1[i]));
        end
        cout = c;
    end
endmodule

module nibble_add_seq #(parameter int NIBBLES = 4) (
    input logic             clk,
    input logic             reset,
    nibble_add_seq_if.slave bus
);
    localparam int W = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_r, b_r, sum_r;
    logic [IW-1:0] idx;
    logic          carry, cout_r;
    logic [3:0]    o;
    logic          co;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic          op_r;
    logic          cin0;
    assign cin0 = bus.op | bus.cin;
`else
    localparam logic op_r = 1'b0;
    logic          cin0;
    assign cin0 = bus.cin;
`endif

    // subtraction inverts B per slice; the forced carry-in completes two's complement
    fulladdR adder (
        .i0  (a_r[{idx, 2'b00} +: 4]),
        .i1  (b_r[{idx, 2'b00} +: 4] ^ {4{op_r}}),
        .cin (carry),
        .o   (o),
        .cout(co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            op_r   <= 1'b0;
`endif
        end else if (state == IDLE && bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            carry <= cin0;
            idx   <= '0;
            state <= RUN;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            op_r  <= bus.op;
`endif
        end else if (state == RUN) begin
            sum_r[{idx, 2'b00} +: 4] <= o;
            carry <= co;
            idx   <= idx + IW'(1);
            if (idx == LAST) begin
                cout_r <= co;
                state  <= DONE;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule
